alu_share_arb: RTL
==================

# alu_share_arb

Two-requester arbiter and sequencer that time-shares the single 64-bit ALU (add/sub/and/or, 4-bit ALU control) in the pipeline. Requester 0 is the EX stage and requester 1 is the branch/address unit. It selects one request per cycle by round-robin, drives the ALU operands and control combinationally, and captures result/zero/overflow into a registered response slot with valid/ready backpressure.

## Interface
- TAG_W, 4, width of the opaque tag carried from request to response
- CNT_W, 32, width of the accepted-operation counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; handshake when valid & ready
- req0_a / req1_a  in  64  operand A
- req0_b / req1_b  in  64  operand B
- req0_op / req1_op  in  4  ALU control: 0010 add, 0110 sub, 0000 and, 0001 or
- req0_tag / req1_tag  in  TAG_W  opaque tag
- alu_a, alu_b  out  64  to ALU operands (muxed from granted requester, else 0)
- alu_ctrl  out  4  to ALU control (granted op, else 0000)
- alu_result  in  64  from ALU, combinational
- alu_zero, alu_overflow  in  1  from ALU, combinational
- rsp_valid  out  1  response slot full
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index that issued the op
- rsp_tag  out  TAG_W  echoed tag
- rsp_result  out  64  registered ALU result
- rsp_zero, rsp_overflow  out  1  registered flags
- rsp_illegal  out  1  op was not one of the four legal codes
- op_count  out  CNT_W  accepted-request count, wraps

## Operation
- slot_free = ~rsp_valid | rsp_ready.
- Arbitration: a priority pointer `prio` (1 bit) selects the preferred requester. If both requesters are valid, grant `prio`. If one is valid, grant it. If none is valid, no grant.
- req_ready[i] = grant[i] & slot_free. At most one bit is set. req_ready never depends on the other requester's data.
- On a handshake with requester g:
  - alu_a/alu_b/alu_ctrl = req{g} fields.
  - Slot loads alu_result, alu_zero, alu_overflow, tag, id=g, and illegal = (op not in {0010,0110,0000,0001}).
  - `prio` <= ~g.
  - op_count increments by 1 and wraps from 2^CNT_W-1 to 0.
- With no handshake, the ALU inputs are driven to zero and ctrl to 0000. `prio` and op_count hold.
- Illegal ops are still accepted and consume a slot. Result/flags are whatever the ALU returns (0,0,0 by ALU default). rsp_illegal=1.
- The slot clears (rsp_valid<=0) when rsp_ready & rsp_valid and no new handshake occurs. Simultaneous drain and load: the slot takes the new op and rsp_valid stays 1.
- Response fields are stable while rsp_valid & ~rsp_ready.
- Two-state FSM on rsp_valid:
  - EMPTY → FULL on a handshake.
  - FULL → FULL on drain+load or stall.
  - FULL → EMPTY on drain without load.

## Timing
- Latency 1: an op handshaken in cycle N has rsp_valid=1 in cycle N+1.
- Throughput: one op per cycle while rsp_ready=1.
- Under contention the requesters alternate every accepted op. Fairness bound: a valid requester waits at most one accepted op of the other.
- Backpressure: with rsp_valid=1 & rsp_ready=0, both req_ready=0 and `prio` holds.
- Reset (asynchronous assert, any cycle including mid-stall) forces:
  - rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_result=0, rsp_zero=0, rsp_overflow=0, rsp_illegal=0
  - op_count=0, prio=0
  - The in-flight response is discarded.
- req_ready and alu_* are combinational. During reset they are 0 because slot_free is still 1 but the registers are cleared: req_ready follows arbitration after rst_n deassertion at the next cycle.

## Structure
- Shared package alu_pkg:
  - ALU op constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110
  - Legal-op check function
  - ALU_W=64
- The arbiter is the natural sub-module: rr_arb2 (inputs req[1:0], prio, en; output one-hot grant).
- The ALU itself stays external; this block does not instantiate it.

## Test plan
- Single add: req0 a=5, b=7, op 0010, tag 3 → next cycle rsp_valid=1, result=12, id=0, tag=3, zero=0, overflow=0, op_count=1.
- Contention: both valid continuously, rsp_ready=1, prio=0 after reset → grants 0,1,0,1 with one response per cycle; req1 sub a=9, b=9 returns zero=1.
- Backpressure: hold rsp_ready=0 for 3 cycles with both valid → req_ready=00, response held bit-stable, prio unchanged; release → drain+load in the same cycle, rsp_valid stays 1.
- Illegal op 1111 from req1 → accepted, rsp_illegal=1, result=0; following legal or (0001) op gives rsp_illegal=0.
- Overflow: req0 sub a=0x8000_0000_0000_0000, b=1 → rsp_overflow=1.
- Reset with rsp_valid=1 and stalled → all outputs 0 immediately; op_count wrap is checked with CNT_W=4 after 16 ops → 0.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU op encodings, legality check and response record shared by the ALU share arbiter.
package alu_pkg;

   localparam int ALU_W = 64;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   typedef struct packed {
      logic             id;
      logic             illegal;
      logic             zero;
      logic             overflow;
      logic [ALU_W-1:0] result;
   } rsp_t;

   function automatic logic op_legal(input logic [3:0] op);
      return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) || (op == ALU_SUB);
   endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Request, ALU and response signals of the ALU share arbiter; slave is the arbiter side.
interface alu_share_arb_if
   import alu_pkg::*;
#(
   parameter int TAG_W = 4,
   parameter int CNT_W = 32
);
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [ALU_W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]       req0_op, req1_op;
   logic [TAG_W-1:0] req0_tag, req1_tag;

   logic [ALU_W-1:0] alu_a, alu_b, alu_result;
   logic [3:0]       alu_ctrl;
   logic             alu_zero, alu_overflow;

   logic             rsp_valid, rsp_ready, rsp_id;
   logic [TAG_W-1:0] rsp_tag;
   logic [ALU_W-1:0] rsp_result;
   logic             rsp_zero, rsp_overflow, rsp_illegal;
   logic [CNT_W-1:0] op_count;

   modport slave (
      input  req_valid, req0_a, req0_b, req0_op, req0_tag, req1_a, req1_b, req1_op, req1_tag,
      input  alu_result, alu_zero, alu_overflow, rsp_ready,
      output req_ready, alu_a, alu_b, alu_ctrl,
      output rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_zero, rsp_overflow, rsp_illegal, op_count
   );

   modport master (
      output req_valid, req0_a, req0_b, req0_op, req0_tag, req1_a, req1_b, req1_op, req1_tag,
      output alu_result, alu_zero, alu_overflow, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_ctrl,
      input  rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_zero, rsp_overflow, rsp_illegal, op_count
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, prio picks the winner under contention.
// Combinational, no grant while en is low.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       prio,
   input  logic       en,
   output logic [1:0] grant
);
   always_comb begin
      grant = 2'b00;
      if (en) begin
         if (&req) grant = prio ? 2'b10 : 2'b01;
         else      grant = req;
      end
   end
endmodule

// File: rtl/alu_share_arb.sv
// Round-robin time-sharing of one external ALU between EX (req 0) and branch/address unit (req 1).
// Latency 1 into a registered response slot; requests stall while the slot is full and not draining.
module alu_share_arb
   import alu_pkg::*;
#(
   parameter int TAG_W = 4,
   parameter int CNT_W = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_share_arb_if.slave bus
);
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]       state, state_nxt;
   logic             live, prio, slot_free, hs, gid;
   logic [1:0]       grant;
   logic [3:0]       op_sel;
   logic [TAG_W-1:0] tag_sel, tag_q;
   logic [CNT_W-1:0] cnt_q;
   rsp_t             rsp_q;

   // live holds arbitration off until the first edge after reset release
   assign slot_free = (state == ST_EMPTY) | bus.rsp_ready;

   rr_arb2 u_arb (
      .req   (bus.req_valid),
      .prio  (prio),
      .en    (slot_free & live),
      .grant (grant)
   );

   assign bus.req_ready = grant;
   assign hs            = |grant;
   assign gid           = grant[1];

   always_comb begin
      bus.alu_a = '0;
      bus.alu_b = '0;
      op_sel    = ALU_AND;
      tag_sel   = '0;
      if (hs) begin
         bus.alu_a = gid ? bus.req1_a   : bus.req0_a;
         bus.alu_b = gid ? bus.req1_b   : bus.req0_b;
         op_sel    = gid ? bus.req1_op  : bus.req0_op;
         tag_sel   = gid ? bus.req1_tag : bus.req0_tag;
      end
   end

   assign bus.alu_ctrl = op_sel;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: state_nxt = hs ? ST_FULL : ST_EMPTY;
         default:  state_nxt = (bus.rsp_ready && !hs) ? ST_EMPTY : ST_FULL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_EMPTY;
         live  <= 1'b0;
         prio  <= 1'b0;
         rsp_q <= '0;
         tag_q <= '0;
         cnt_q <= '0;
      end else begin
         state <= state_nxt;
         live  <= 1'b1;
         if (hs) begin
            rsp_q.id       <= gid;
            rsp_q.illegal  <= ~op_legal(op_sel);
            rsp_q.zero     <= bus.alu_zero;
            rsp_q.overflow <= bus.alu_overflow;
            rsp_q.result   <= bus.alu_result;
            tag_q          <= tag_sel;
            prio           <= ~gid;
            cnt_q          <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.rsp_valid    = (state == ST_FULL);
   assign bus.rsp_id       = rsp_q.id;
   assign bus.rsp_tag      = tag_q;
   assign bus.rsp_result   = rsp_q.result;
   assign bus.rsp_zero     = rsp_q.zero;
   assign bus.rsp_overflow = rsp_q.overflow;
   assign bus.rsp_illegal  = rsp_q.illegal;
   assign bus.op_count     = cnt_q;
endmodule
